// File: rtl/regbank_controller_pkg.sv
// Shared types and defaults for the register-bank write-port controller.
// Round-robin priority encoding and a small pointer-update helper.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef REG_SEL
`define REG_SEL 5
`endif
`ifndef NUM_REGS
`define NUM_REGS 32
`endif
`ifndef PRI_ALU
`define PRI_ALU 1'b0
`endif
`ifndef PRI_MEM
`define PRI_MEM 1'b1
`endif

package regbank_controller_pkg;

    typedef enum logic {
        PTR_ALU = `PRI_ALU,
        PTR_MEM = `PRI_MEM
    } rr_ptr_e;

    // Priority passes to the other side after any grant; idle holds.
    function automatic rr_ptr_e next_ptr(
        input rr_ptr_e ptr,
        input logic    gnt_alu,
        input logic    gnt_mem
    );
        rr_ptr_e nxt;
        nxt = ptr;
        if (gnt_alu)
            nxt = PTR_MEM;
        else if (gnt_mem)
            nxt = PTR_ALU;
        return nxt;
    endfunction

endpackage

// File: rtl/regbank_controller_rr_arbiter2.sv
// Two-way round-robin arbiter for the write port.
// Grants are combinational; the priority pointer is registered.
module rr_arbiter2
    import regbank_controller_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    rr_ptr_e ptr;

    // A lone requester wins; on contention the pointer holder wins.
    always_comb begin
        gnt_alu = req_alu & (~req_mem | (ptr == PTR_ALU));
        gnt_mem = req_mem & (~req_alu | (ptr == PTR_MEM));
    end

    // Pointer rotates away from whoever was just granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= PTR_ALU;
        else
            ptr <= next_ptr(ptr, gnt_alu, gnt_mem);
    end

endmodule

// File: rtl/regbank_controller.sv
// Register-bank write-port controller: writeback arbitration,
// busy scoreboard, hazard detection and the registered write stage.
module regbank_controller
    import regbank_controller_pkg::*;
#(
    parameter int WIDTH    = `WIDTH,
    parameter int REG_SEL  = `REG_SEL,
    parameter int NUM_REGS = `NUM_REGS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                issue_valid,
    input  logic [REG_SEL-1:0]  issue_addr,
    input  logic [REG_SEL-1:0]  rd_addr_a,
    input  logic [REG_SEL-1:0]  rd_addr_b,
    output logic                hazard,
    input  logic                alu_valid,
    input  logic [REG_SEL-1:0]  alu_addr,
    input  logic [WIDTH-1:0]    alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [REG_SEL-1:0]  mem_addr,
    input  logic [WIDTH-1:0]    mem_data,
    output logic                mem_ready,
    output logic                rb_write_enable,
    output logic [REG_SEL-1:0]  rb_addr_z,
    output logic [WIDTH-1:0]    rb_data_z,
    output logic [NUM_REGS-1:0] busy,
    output logic                sb_error
);

    localparam logic [NUM_REGS-1:0] ONE =
        {{(NUM_REGS-1){1'b0}}, 1'b1};

    // Addresses beyond NUM_REGS read as not busy.
    function automatic logic bit_at(
        input logic [NUM_REGS-1:0] v,
        input logic [REG_SEL-1:0]  a
    );
        logic [NUM_REGS-1:0] s;
        s = v >> a;
        return s[0];
    endfunction

    logic                gnt_alu;
    logic                gnt_mem;
    logic                wb_fire;
    logic [REG_SEL-1:0]  wb_addr;
    logic [WIDTH-1:0]    wb_data;
    logic                wb_was_busy;
    logic                busy_hit;
    logic                pend_hit;
    logic                issue_ok;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt_alu (gnt_alu),
        .gnt_mem (gnt_mem)
    );

    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;

    // Select the granted writeback; a grant implies valid.
    always_comb begin
        wb_fire = gnt_alu | gnt_mem;
        wb_addr = gnt_alu ? alu_addr : mem_addr;
        wb_data = gnt_alu ? alu_data : mem_data;
        wb_was_busy = bit_at(busy, wb_addr);
    end

    // Stall on an outstanding write or on the write still in flight.
    always_comb begin
        busy_hit = bit_at(busy, rd_addr_a)
                 | bit_at(busy, rd_addr_b)
                 | bit_at(busy, issue_addr);
        pend_hit = rb_write_enable
                 & ((rb_addr_z == rd_addr_a)
                 |  (rb_addr_z == rd_addr_b)
                 |  (rb_addr_z == issue_addr));
        hazard   = busy_hit | pend_hit;
        issue_ok = issue_valid & ~hazard;
    end

    // One-hot scoreboard updates; set is applied after clear.
    always_comb begin
        set_vec = issue_ok ? (ONE << issue_addr) : '0;
        clr_vec = wb_fire  ? (ONE << wb_addr)    : '0;
    end

    // Scoreboard and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= '0;
            sb_error <= 1'b0;
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
            if (wb_fire && !wb_was_busy)
                sb_error <= 1'b1;
        end
    end

    // Registered write stage toward the register bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rb_write_enable <= 1'b0;
            rb_addr_z       <= '0;
            rb_data_z       <= '0;
        end else begin
            rb_write_enable <= wb_fire;
            if (wb_fire) begin
                rb_addr_z <= wb_addr;
                rb_data_z <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_regbank_controller.sv
// Directed bench for regbank_controller.
// Vector table plus hand-written reset/arbitration sequence.
module tb_regbank_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        hazard;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        rb_write_enable;
    logic [4:0]  rb_addr_z;
    logic [31:0] rb_data_z;
    logic [31:0] busy;
    logic        sb_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regbank_controller #(
        .WIDTH(32), .REG_SEL(5), .NUM_REGS(32)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .issue_valid     (issue_valid),
        .issue_addr      (issue_addr),
        .rd_addr_a       (rd_addr_a),
        .rd_addr_b       (rd_addr_b),
        .hazard          (hazard),
        .alu_valid       (alu_valid),
        .alu_addr        (alu_addr),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .mem_valid       (mem_valid),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .rb_write_enable (rb_write_enable),
        .rb_addr_z       (rb_addr_z),
        .rb_data_z       (rb_data_z),
        .busy            (busy),
        .sb_error        (sb_error)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_haz;
        logic        e_ard;
        logic        e_mrd;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        issue_valid = 0; issue_addr = 0; rd_addr_a = 0; rd_addr_b = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
    endtask

    task automatic setv(input int i,
        input logic iv, input logic [4:0] ia, input logic [4:0] ra,
        input logic [4:0] rb, input logic av, input logic [4:0] aa,
        input logic [31:0] ad, input logic mv, input logic [4:0] ma,
        input logic [31:0] md, input logic eh, input logic ear,
        input logic emr, input logic ew, input logic [4:0] ea,
        input logic [31:0] ed, input logic [31:0] eb, input logic ee);
        vt[i].iv = iv; vt[i].ia = ia; vt[i].ra = ra; vt[i].rb = rb;
        vt[i].av = av; vt[i].aa = aa; vt[i].ad = ad;
        vt[i].mv = mv; vt[i].ma = ma; vt[i].md = md;
        vt[i].e_haz = eh; vt[i].e_ard = ear; vt[i].e_mrd = emr;
        vt[i].e_we = ew; vt[i].e_addr = ea; vt[i].e_data = ed;
        vt[i].e_busy = eb; vt[i].e_err = ee;
    endtask

    initial begin
        //     iv ia  ra rb  av aa  ad       mv ma md
        //     hz ar mr we addr data busy err
        setv(0,  1, 5, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 32'h20, 0);
        setv(1,  1, 6, 5, 0, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 32'h20, 0);
        setv(2,  0, 0, 0, 0, 1, 5, 32'hDEAD, 0, 0, 0,
                 0, 1, 0, 1, 5, 32'hDEAD, 32'h0, 0);
        setv(3,  0, 0, 0, 5, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 5, 32'hDEAD, 32'h0, 0);
        setv(4,  1, 1, 5, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 5, 32'hDEAD, 32'h2, 0);
        setv(5,  1, 2, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 5, 32'hDEAD, 32'h6, 0);
        setv(6,  1, 3, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 5, 32'hDEAD, 32'hE, 0);
        setv(7,  1, 4, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 5, 32'hDEAD, 32'h1E, 0);
        setv(8,  1, 9, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 5, 32'hDEAD, 32'h21E, 0);
        setv(9,  0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99,
                 0, 0, 1, 1, 9, 32'h99, 32'h1E, 0);
        setv(10, 1, 6, 0, 0, 1, 1, 32'hA1, 1, 2, 32'hB2,
                 0, 1, 0, 1, 1, 32'hA1, 32'h5C, 0);
        setv(11, 0, 0, 0, 0, 1, 3, 32'hA3, 1, 2, 32'hB2,
                 0, 0, 1, 1, 2, 32'hB2, 32'h58, 0);
        setv(12, 0, 0, 0, 0, 1, 3, 32'hA3, 1, 4, 32'hB4,
                 0, 1, 0, 1, 3, 32'hA3, 32'h50, 0);
        setv(13, 0, 0, 0, 0, 1, 6, 32'hA6, 1, 4, 32'hB4,
                 0, 0, 1, 1, 4, 32'hB4, 32'h40, 0);
        setv(14, 0, 0, 0, 0, 1, 6, 32'hA6, 0, 0, 0,
                 0, 1, 0, 1, 6, 32'hA6, 32'h0, 0);
        setv(15, 1, 7, 0, 0, 1, 7, 32'h77, 0, 0, 0,
                 0, 1, 0, 1, 7, 32'h77, 32'h80, 1);
        setv(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 7, 32'h77, 32'h80, 1);
        setv(17, 1, 7, 1, 2, 0, 0, 0, 0, 0, 0,
                 1, 0, 0, 0, 7, 32'h77, 32'h80, 1);
        setv(18, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h70,
                 0, 0, 1, 1, 7, 32'h70, 32'h0, 1);

        reset_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", rb_write_enable, 0);
        chk("rst_addr", rb_addr_z, 0);
        chk("rst_data", rb_data_z, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", sb_error, 0);

        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if (i != 0) @(negedge clk);
            issue_valid = vt[i].iv; issue_addr = vt[i].ia;
            rd_addr_a = vt[i].ra; rd_addr_b = vt[i].rb;
            alu_valid = vt[i].av; alu_addr = vt[i].aa;
            alu_data = vt[i].ad;
            mem_valid = vt[i].mv; mem_addr = vt[i].ma;
            mem_data = vt[i].md;
            #1;
            chk($sformatf("v%0d_hazard", i), hazard, vt[i].e_haz);
            chk($sformatf("v%0d_alu_rdy", i), alu_ready, vt[i].e_ard);
            chk($sformatf("v%0d_mem_rdy", i), mem_ready, vt[i].e_mrd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), rb_write_enable, vt[i].e_we);
            chk($sformatf("v%0d_addr", i), rb_addr_z, vt[i].e_addr);
            chk($sformatf("v%0d_data", i), rb_data_z, vt[i].e_data);
            chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
            chk($sformatf("v%0d_err", i), sb_error, vt[i].e_err);
        end

        // Write stage is active here; reset must clear it at once.
        chk("pre_rst_we", rb_write_enable, 1);
        drive_idle();
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", rb_write_enable, 0);
        chk("mid_rst_addr", rb_addr_z, 0);
        chk("mid_rst_data", rb_data_z, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", sb_error, 0);

        // Pointer was left at ALU-after-MEM? Reset forces it to ALU.
        @(negedge clk);
        reset_n = 1'b1;
        issue_valid = 1; issue_addr = 1;
        #1;
        chk("post_rst_haz", hazard, 0);
        @(negedge clk);
        issue_valid = 1; issue_addr = 2;
        @(negedge clk);
        drive_idle();
        alu_valid = 1; alu_addr = 1; alu_data = 32'h11;
        mem_valid = 1; mem_addr = 2; mem_data = 32'h22;
        #1;
        chk("post_rst_alu_rdy", alu_ready, 1);
        chk("post_rst_mem_rdy", mem_ready, 0);
        @(posedge clk);
        #1;
        chk("post_rst_we", rb_write_enable, 1);
        chk("post_rst_addr", rb_addr_z, 1);
        chk("post_rst_busy", busy, 32'h4);
        @(negedge clk);
        alu_addr = 2; alu_data = 32'h33;
        #1;
        chk("rr_alu_rdy", alu_ready, 0);
        chk("rr_mem_rdy", mem_ready, 1);
        @(posedge clk);
        #1;
        chk("rr_addr", rb_addr_z, 2);
        chk("rr_data", rb_data_z, 32'h22);
        chk("rr_busy", busy, 32'h0);
        chk("rr_err", sb_error, 0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("idle_rdy", {alu_ready, mem_ready}, 0);
        @(posedge clk);
        #1;
        chk("idle_we", rb_write_enable, 0);
        chk("idle_hold", rb_data_z, 32'h22);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_controller.md
# regbank_controller

Sequencing and sharing controller for the register bank's single write port. Two writeback requesters (ALU and memory unit) are arbitrated round-robin onto the port with one registered stage. A per-register busy scoreboard tracks writes between issue and writeback and raises a read-after-write / write-after-write hazard to the decoder. Sits between decode/execute and the register bank; the register bank's `write_enable`/`addr_z`/`data_z` are driven only from here.

## Interface
- `WIDTH`, default `` `WIDTH ``: data width.
- `REG_SEL`, default `` `REG_SEL ``: register address width.
- `NUM_REGS`, default `` `NUM_REGS ``: register count.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  decoder issuing an instruction that writes `issue_addr`.
- `issue_addr`  in  REG_SEL  destination register of the issuing instruction.
- `rd_addr_a`, `rd_addr_b`  in  REG_SEL  source registers of the issuing instruction.
- `hazard`  out  1  combinational; the issuing instruction must stall.
- `alu_valid`  in  1  ALU writeback request.
- `alu_addr`  in  REG_SEL  ALU writeback address.
- `alu_data`  in  WIDTH  ALU writeback data.
- `alu_ready`  out  1  combinational grant to the ALU.
- `mem_valid`, `mem_addr`, `mem_data`, `mem_ready`: same as the ALU set, for the memory unit.
- `rb_write_enable`  out  1  registered; to the register bank's `write_enable`.
- `rb_addr_z`  out  REG_SEL  registered; to the register bank's `addr_z`.
- `rb_data_z`  out  WIDTH  registered; to the register bank's `data_z`.
- `busy`  out  NUM_REGS  scoreboard; bit i set means register i has a write outstanding.
- `sb_error`  out  1  sticky; a writeback targeted a non-busy register.

## Operation
- **Hazard:** `hazard = busy[rd_addr_a] | busy[rd_addr_b] | busy[issue_addr]`, OR a pending write, i.e. `rb_write_enable & (rb_addr_z == rd_addr_a | rd_addr_b | issue_addr)`.
  - The pending-write term covers the cycle in which the register bank has not yet absorbed the write.
  - `hazard` is evaluated regardless of `issue_valid`.
- **Issue accept:** `issue_valid & ~hazard` sets `busy[issue_addr]` at the next edge.
- **Arbitration:** a one-bit round-robin pointer (`PRI_ALU` / `PRI_MEM`) holds priority.
  - Only one requester valid: that requester is granted.
  - Both valid: the pointer holder is granted.
  - After any grant, the pointer moves to the other requester.
  - No request: the pointer holds.
  - `*_ready` equals the grant. A handshake is `valid & ready`.
  - `ready` is never asserted without `valid`.
- **Writeback handshake, effects at the next edge:**
  - `rb_write_enable` ← 1; `rb_addr_z` / `rb_data_z` ← the granted address/data.
  - `busy[addr]` is cleared.
  - If `busy[addr]` was 0, `sb_error` ← 1.
- **No handshake:** `rb_write_enable` ← 0; `rb_addr_z` / `rb_data_z` hold their values.
- **Same-edge set and clear of one register** (issue to X while a writeback to non-busy X is granted): the set wins, `busy[X]` = 1, and `sb_error` is set.
  - Issue and writeback to *different* registers in the same cycle both take effect.
- **Requester protocol:** requesters hold `valid`/`addr`/`data` stable until `ready`. Back-to-back grants are allowed: one write per cycle, full throughput.
- **Reset:** asserting `reset_n` low at any time, immediately and asynchronously:
  - clears `busy`, `rb_write_enable`, `rb_addr_z`, `rb_data_z` and `sb_error`;
  - sets the pointer to `PRI_ALU`;
  - drops any in-flight write.
  - Deassertion is synchronous to `clk` externally.

## Timing
- Writeback handshake at edge N → `rb_write_enable` high in cycle N+1 → register bank updated at edge N+2.
- Issue accept at edge N → `busy` bit visible in cycle N+1.
- Writeback to X at edge N: `hazard` for X is low from cycle N+2.
  - In cycle N+1 the pending-write term keeps it high.
- Reset values: all outputs 0, including `busy = 0`. `*_ready` and `hazard` follow their combinational inputs.

## Structure
- `defines.vh` already holds `` `WIDTH ``, `` `REG_SEL `` and `` `NUM_REGS ``. Add `` `PRI_ALU = 1'b0 `` and `` `PRI_MEM = 1'b1 `` there.
- One sub-module, `rr_arbiter2`: two request inputs, two grant outputs, internal pointer, and `clk`/`reset_n`.
- Scoreboard, hazard logic and output register live in `regbank_controller`.

## Test plan
- **Reset, then issue:** `issue_valid` = 1, `issue_addr` = 5 → `busy` = 0x20 next cycle. A second issue reading `rd_addr_a` = 5 sees `hazard` = 1.
- **ALU writeback:** ALU writes r5 = 0xDEAD → `alu_ready` = 1 same cycle; `rb_write_enable` = 1, `rb_addr_z` = 5, `rb_data_z` = 0xDEAD next cycle; `busy[5]` = 0. `hazard` on r5 stays 1 in that cycle and is 0 in the cycle after.
- **Contention:** both requesters valid continuously for 4 cycles with r1–r4 busy → grants alternate ALU, MEM, ALU, MEM; four consecutive `rb_write_enable` pulses.
- **Error path:** writeback to non-busy r7 → `sb_error` = 1 and stays 1 until reset. Simultaneous issue to r7 leaves `busy[7]` = 1.
- **Mid-operation reset:** `reset_n` dropped in the cycle where `rb_write_enable` = 1 → outputs 0 immediately. After release, the first contention grant goes to ALU.
- **WAW stall:** r3 busy, issue with `issue_addr` = 3 and unrelated sources → `hazard` = 1 and `busy` unchanged.
